// File: rtl/mlp_pkg.sv
// Shared types, default sizes and arithmetic helpers for the MLP MAC array.
// Sizes here are the defaults used by the interface, the lanes and the top level.
package mlp_pkg;

   localparam int DEF_A_WIDTH   = 16;
   localparam int DEF_B_WIDTH   = 16;
   localparam int DEF_FRAC_BITS = 8;
   localparam int DEF_NUM_LANES = 4;
   localparam int DEF_MAX_LEN   = 256;
   localparam int DEF_ACC_WIDTH = 48;
   localparam int DEF_OUT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FINISH = 2'd2,
      OUT    = 2'd3
   } state_t;

   typedef struct packed {
      logic signed [63:0] value;
      logic               sat;
   } sat_res_t;

   // The rounded sum is widened to 64 bits for saturation, so the accumulator must stay below that.
   function automatic bit acc_width_ok(input int a_w, input int b_w, input int max_len, input int acc_w);
      return (acc_w >= a_w + b_w + $clog2(max_len) + 1) && (acc_w <= 63);
   endfunction

   localparam bit DEF_ACC_OK = acc_width_ok(DEF_A_WIDTH, DEF_B_WIDTH, DEF_MAX_LEN, DEF_ACC_WIDTH);

   function automatic sat_res_t sat_round(input logic signed [63:0] r, input int out_w);
      sat_res_t           res;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (out_w - 1));
      if (r > max_v) begin
         res.value = max_v;
         res.sat   = 1'b1;
      end else if (r < min_v) begin
         res.value = min_v;
         res.sat   = 1'b1;
      end else begin
         res.value = r;
         res.sat   = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/mlp_mac_array_if.sv
// Control, beat and result bundle between the MAC array and its memories / output buffer.
interface mlp_mac_array_if
   import mlp_pkg::*;
#(
   parameter int A_WIDTH   = DEF_A_WIDTH,
   parameter int B_WIDTH   = DEF_B_WIDTH,
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int MAX_LEN   = DEF_MAX_LEN,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();

   logic                             start;
   logic [$clog2(MAX_LEN+1)-1:0]     vec_len;
   logic                             relu_en;
   logic [NUM_LANES*OUT_WIDTH-1:0]   bias;
   logic                             in_valid;
   logic                             in_ready;
   logic [A_WIDTH-1:0]               in_a;
   logic [NUM_LANES*B_WIDTH-1:0]     in_b;
   logic                             out_valid;
   logic                             out_ready;
   logic [NUM_LANES*OUT_WIDTH-1:0]   out_data;
   logic [NUM_LANES-1:0]             sat_flag;
   logic                             busy;

   modport master (
      output start, vec_len, relu_en, bias, in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, sat_flag, busy
   );

   modport slave (
      input  start, vec_len, relu_en, bias, in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, sat_flag, busy
   );

endinterface

// File: rtl/mlp_mac_lane.sv
// One neuron lane: signed multiply-accumulate, then bias, round-half-up, saturate
// and optional ReLU into a registered result.
module mlp_mac_lane
   import mlp_pkg::*;
#(
   parameter int A_WIDTH   = DEF_A_WIDTH,
   parameter int B_WIDTH   = DEF_B_WIDTH,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        acc_en,
   input  logic                        fin_en,
   input  logic                        relu,
   input  logic signed [A_WIDTH-1:0]   a,
   input  logic signed [B_WIDTH-1:0]   b,
   input  logic signed [OUT_WIDTH-1:0] bias,
   output logic [OUT_WIDTH-1:0]        out_data,
   output logic                        sat
);

   localparam int PW = A_WIDTH + B_WIDTH;
   localparam int SW = ACC_WIDTH + 1;
   localparam logic signed [SW-1:0] HALF_LSB = SW'(1'b1) <<< (FRAC_BITS - 1);

   logic signed [PW-1:0]        prod_s;
   logic signed [ACC_WIDTH-1:0] acc_r;
   logic signed [SW-1:0]        sum_s;
   logic signed [SW-1:0]        rnd_s;
   sat_res_t                    res_s;
   logic [OUT_WIDTH-1:0]        final_s;
   logic [OUT_WIDTH-1:0]        out_r;
   logic                        sat_r;
   logic                        unused_hi_s;

   assign prod_s = PW'(a) * PW'(b);

   // Bias is aligned to the accumulator's binary point; one extra bit keeps the sum exact.
   always_comb begin
      sum_s = SW'(acc_r) + (SW'(bias) <<< FRAC_BITS) + HALF_LSB;
      rnd_s = sum_s >>> FRAC_BITS;
      res_s = sat_round(64'(rnd_s), OUT_WIDTH);
      if (relu && res_s.value[63]) begin
         final_s = {OUT_WIDTH{1'b0}};
      end else begin
         final_s = res_s.value[OUT_WIDTH-1:0];
      end
   end

   assign unused_hi_s = ^res_s.value[63:OUT_WIDTH];

   // Accumulator: cleared when a pass is accepted, advanced on every consumed beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= {ACC_WIDTH{1'b0}};
      end else if (clr) begin
         acc_r <= {ACC_WIDTH{1'b0}};
      end else if (acc_en) begin
         acc_r <= acc_r + ACC_WIDTH'(prod_s);
      end
   end

   // Result register: loads at the end of FINISH and holds until the next pass finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r <= {OUT_WIDTH{1'b0}};
         sat_r <= 1'b0;
      end else if (fin_en) begin
         out_r <= final_s;
         sat_r <= res_s.sat;
      end
   end

   assign out_data = out_r;
   assign sat      = sat_r;

endmodule

// File: rtl/mlp_mac_array.sv
// Multi-lane fixed-point dot-product engine: pass FSM, beat counter, latched
// per-pass configuration and NUM_LANES MAC lanes sharing one broadcast activation.
module mlp_mac_array
   import mlp_pkg::*;
#(
   parameter int A_WIDTH   = DEF_A_WIDTH,
   parameter int B_WIDTH   = DEF_B_WIDTH,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int MAX_LEN   = DEF_MAX_LEN,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
   input logic             clk,
   input logic             rst,
   mlp_mac_array_if.slave  bus
);

   localparam int LW = $clog2(MAX_LEN + 1);

   generate
      if (!acc_width_ok(A_WIDTH, B_WIDTH, MAX_LEN, ACC_WIDTH)) begin : g_bad_acc
         $error("mlp_mac_array: ACC_WIDTH too small for A_WIDTH+B_WIDTH+clog2(MAX_LEN)+1");
      end
   endgenerate

   state_t                         state_r;
   state_t                         state_nx_s;
   logic [LW-1:0]                  cnt_r;
   logic [LW-1:0]                  vec_len_r;
   logic                           relu_r;
   logic [NUM_LANES*OUT_WIDTH-1:0] bias_r;
   logic                           in_ready_r;
   logic                           out_valid_r;
   logic                           busy_r;
   logic                           start_ok_s;
   logic                           beat_s;
   logic                           last_s;
   logic                           fin_s;
   logic [NUM_LANES*OUT_WIDTH-1:0] out_data_s;
   logic [NUM_LANES-1:0]           sat_s;

   // Next-state decode; start is only honoured in IDLE and a zero-length pass skips ACCUM.
   always_comb begin
      start_ok_s = (state_r == IDLE) && bus.start;
      beat_s     = (state_r == ACCUM) && bus.in_valid && in_ready_r;
      last_s     = beat_s && (cnt_r == vec_len_r - LW'(1'b1));
      fin_s      = (state_r == FINISH);
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nx_s = (bus.vec_len == LW'(1'b0)) ? FINISH : ACCUM;
            end else begin
               state_nx_s = IDLE;
            end
         end
         ACCUM: begin
            if (last_s) begin
               state_nx_s = FINISH;
            end else begin
               state_nx_s = ACCUM;
            end
         end
         FINISH: state_nx_s = OUT;
         OUT: begin
            if (bus.out_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = OUT;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register; status outputs are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == ACCUM);
         out_valid_r <= (state_nx_s == OUT);
         busy_r      <= (state_nx_s != IDLE);
      end
   end

   // Per-pass configuration latch and beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= {LW{1'b0}};
         vec_len_r <= {LW{1'b0}};
         relu_r    <= 1'b0;
         bias_r    <= {(NUM_LANES*OUT_WIDTH){1'b0}};
      end else if (start_ok_s) begin
         cnt_r     <= {LW{1'b0}};
         vec_len_r <= bus.vec_len;
         relu_r    <= bus.relu_en;
         bias_r    <= bus.bias;
      end else if (beat_s) begin
         cnt_r     <= cnt_r + LW'(1'b1);
      end
   end

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      mlp_mac_lane #(
         .A_WIDTH   (A_WIDTH),
         .B_WIDTH   (B_WIDTH),
         .FRAC_BITS (FRAC_BITS),
         .ACC_WIDTH (ACC_WIDTH),
         .OUT_WIDTH (OUT_WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clr      (start_ok_s),
         .acc_en   (beat_s),
         .fin_en   (fin_s),
         .relu     (relu_r),
         .a        (bus.in_a),
         .b        (bus.in_b[gi*B_WIDTH +: B_WIDTH]),
         .bias     (bias_r[gi*OUT_WIDTH +: OUT_WIDTH]),
         .out_data (out_data_s[gi*OUT_WIDTH +: OUT_WIDTH]),
         .sat      (sat_s[gi])
      );
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.out_data  = out_data_s;
   assign bus.sat_flag  = sat_s;

endmodule

// File: tb/tb_mlp_mac_array.sv
// Directed bench for mlp_mac_array with Q8.8 vectors and hand-computed results.
module tb_mlp_mac_array;
   import mlp_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mlp_mac_array_if bus ();

   mlp_mac_array dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_vec;
   int          n_err;
   int          lat;
   logic        got_out;
   logic [15:0] pass_a [0:7];
   logic [63:0] pass_b [0:7];

   task automatic fill(input int n, input logic [15:0] a, input logic [63:0] b);
      for (int i = 0; i < n; i++) begin
         pass_a[i] = a;
         pass_b[i] = b;
      end
   endtask

   // Starts a pass, feeds len beats (odd slots idle when gap!=0), waits for out_valid.
   task automatic drive_pass(input logic [8:0] len, input logic relu, input logic [63:0] bias_v, input int gap);
      int i;
      int k;
      int budget;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.vec_len = len;
      bus.relu_en = relu;
      bus.bias    = bias_v;
      i = 0;
      k = 0;
      budget = 0;
      while (i < int'(len) && budget < 100) begin
         @(negedge clk);
         bus.start = 1'b0;
         budget++;
         if (gap != 0 && (k % 2) == 1) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_a     = pass_a[i];
            bus.in_b     = pass_b[i];
            if (bus.in_ready) i++;
         end
         k++;
      end
      lat = 0;
      got_out = 1'b0;
      while (!got_out && lat < 20) begin
         @(negedge clk);
         bus.start    = 1'b0;
         bus.in_valid = 1'b0;
         lat++;
         got_out = bus.out_valid;
      end
   endtask

   task automatic accept_out();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_status: valid/ready/busy=%b%b%b expected 000", bus.out_valid, bus.in_ready, bus.busy);
      end
      n_vec++;
      if (bus.out_data !== 64'h0 || bus.sat_flag !== 4'h0) begin
         n_err++;
         $display("FAIL reset_data: out=%h sat=%b expected 0/0000", bus.out_data, bus.sat_flag);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      fill(3, 16'h0100, {4{16'h0200}});
      drive_pass(9'd3, 1'b0, 64'h0, 0);
      n_vec++;
      if (!got_out || lat != 2) begin
         n_err++;
         $display("FAIL basic_latency: got %0d cycles (valid=%b) expected 2", lat, got_out);
      end
      n_vec++;
      if (bus.out_data !== {4{16'h0600}} || bus.sat_flag !== 4'h0) begin
         n_err++;
         $display("FAIL basic_data: out=%h sat=%b expected %h/0000", bus.out_data, bus.sat_flag, {4{16'h0600}});
      end
      accept_out();
   endtask

   task automatic test_gaps();
      fill(3, 16'h0100, {4{16'h0200}});
      drive_pass(9'd3, 1'b0, 64'h0, 1);
      n_vec++;
      if (!got_out || bus.out_data !== {4{16'h0600}}) begin
         n_err++;
         $display("FAIL gap_data: out=%h valid=%b expected %h", bus.out_data, got_out, {4{16'h0600}});
      end
      accept_out();
   endtask

   task automatic test_round_bias();
      fill(1, 16'h0001, {4{16'h0080}});
      drive_pass(9'd1, 1'b0, {4{16'h0100}}, 0);
      n_vec++;
      if (bus.out_data !== {4{16'h0101}} || bus.sat_flag !== 4'h0) begin
         n_err++;
         $display("FAIL round_half_up: out=%h sat=%b expected %h/0000", bus.out_data, bus.sat_flag, {4{16'h0101}});
      end
      accept_out();
      drive_pass(9'd0, 1'b0, {4{16'hFF00}}, 0);
      n_vec++;
      if (!got_out || lat != 2) begin
         n_err++;
         $display("FAIL zero_len_latency: got %0d cycles (valid=%b) expected 2", lat, got_out);
      end
      n_vec++;
      if (bus.out_data !== {4{16'hFF00}}) begin
         n_err++;
         $display("FAIL zero_len_bias: out=%h expected %h", bus.out_data, {4{16'hFF00}});
      end
      accept_out();
   endtask

   task automatic test_saturation();
      fill(4, 16'h7FFF, {4{16'h7FFF}});
      drive_pass(9'd4, 1'b0, 64'h0, 0);
      n_vec++;
      if (bus.out_data !== {4{16'h7FFF}} || bus.sat_flag !== 4'hF) begin
         n_err++;
         $display("FAIL sat_pos: out=%h sat=%b expected %h/1111", bus.out_data, bus.sat_flag, {4{16'h7FFF}});
      end
      accept_out();
      fill(4, 16'h8000, {4{16'h7FFF}});
      drive_pass(9'd4, 1'b0, 64'h0, 0);
      n_vec++;
      if (bus.out_data !== {4{16'h8000}} || bus.sat_flag !== 4'hF) begin
         n_err++;
         $display("FAIL sat_neg: out=%h sat=%b expected %h/1111", bus.out_data, bus.sat_flag, {4{16'h8000}});
      end
      accept_out();
      drive_pass(9'd4, 1'b1, 64'h0, 0);
      n_vec++;
      if (bus.out_data !== 64'h0 || bus.sat_flag !== 4'hF) begin
         n_err++;
         $display("FAIL sat_neg_relu: out=%h sat=%b expected 0/1111", bus.out_data, bus.sat_flag);
      end
      accept_out();
   endtask

   task automatic test_relu();
      fill(1, 16'hFE80, {4{16'h0100}});
      drive_pass(9'd1, 1'b0, 64'h0, 0);
      n_vec++;
      if (bus.out_data !== {4{16'hFE80}} || bus.sat_flag !== 4'h0) begin
         n_err++;
         $display("FAIL relu_off: out=%h sat=%b expected %h/0000", bus.out_data, bus.sat_flag, {4{16'hFE80}});
      end
      accept_out();
      drive_pass(9'd1, 1'b1, 64'h0, 0);
      n_vec++;
      if (bus.out_data !== 64'h0 || bus.sat_flag !== 4'h0) begin
         n_err++;
         $display("FAIL relu_on: out=%h sat=%b expected 0/0000", bus.out_data, bus.sat_flag);
      end
      accept_out();
   endtask

   task automatic test_hold();
      fill(3, 16'h0100, {4{16'h0200}});
      drive_pass(9'd3, 1'b0, 64'h0, 0);
      for (int c = 0; c < 5; c++) begin
         n_vec++;
         if (bus.out_data !== {4{16'h0600}} || bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_cycle%0d: out=%h busy=%b valid=%b expected %h/1/1", c, bus.out_data, bus.busy, bus.out_valid, {4{16'h0600}});
         end
         bus.start   = (c < 4);
         bus.vec_len = 9'd0;
         @(negedge clk);
      end
      bus.start = 1'b0;
      accept_out();
      n_vec++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== {4{16'h0600}}) begin
         n_err++;
         $display("FAIL hold_release: busy=%b valid=%b out=%h expected 0/0/%h", bus.busy, bus.out_valid, bus.out_data, {4{16'h0600}});
      end
      @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL hold_start_ignored: busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.start   = 1'b1;
      bus.vec_len = 9'd4;
      bus.relu_en = 1'b0;
      bus.bias    = 64'h0;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h0100;
      bus.in_b     = {4{16'h0100}};
      @(negedge clk);
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_status: busy=%b valid=%b ready=%b expected 000", bus.busy, bus.out_valid, bus.in_ready);
      end
      fill(1, 16'h0100, {4{16'h0300}});
      drive_pass(9'd1, 1'b0, 64'h0, 0);
      n_vec++;
      if (!got_out || bus.out_data !== {4{16'h0300}}) begin
         n_err++;
         $display("FAIL reset_mid_fresh: out=%h valid=%b expected %h", bus.out_data, got_out, {4{16'h0300}});
      end
      accept_out();
   endtask

   task automatic test_lanes();
      fill(1, 16'h0200, {16'h0100, 16'hFF00, 16'h0000, 16'h0080});
      drive_pass(9'd1, 1'b0, 64'h0, 0);
      n_vec++;
      if (bus.out_data !== {16'h0200, 16'hFE00, 16'h0000, 16'h0100} || bus.sat_flag !== 4'h0) begin
         n_err++;
         $display("FAIL lane_indep: out=%h sat=%b expected 0200fe0000000100/0000", bus.out_data, bus.sat_flag);
      end
      accept_out();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.vec_len   = 9'd0;
      bus.relu_en   = 1'b0;
      bus.bias      = 64'h0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 16'h0;
      bus.in_b      = 64'h0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_round_bias();
      test_saturation();
      test_relu();
      test_hold();
      test_reset_mid();
      test_lanes();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
